// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared load-type encodings, register-zero constant and muldiv FIFO entry type
package wb_pkg;

  localparam logic [2:0] LDT_LW  = 3'd0;
  localparam logic [2:0] LDT_LH  = 3'd1;
  localparam logic [2:0] LDT_LHU = 3'd2;
  localparam logic [2:0] LDT_LB  = 3'd3;
  localparam logic [2:0] LDT_LBU = 3'd4;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } md_entry_t;

endpackage

// File: rtl/wb_md_fifo.sv
// rtl/wb_md_fifo.sv - muldiv result FIFO with pending-destination mask over its live entries
module wb_md_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int NREG  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  md_entry_t       push_entry,
  input  logic            pop,
  output md_entry_t       head,
  output logic            full,
  output logic            empty,
  output logic [NREG-1:0] pend_mask
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  md_entry_t     mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [AW:0]   count;
  logic [AW-1:0] off;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= push_entry;
  end

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    pend_mask = '0;
    off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rptr[AW-1:0];
      if (({1'b0, off} < count) && (mem[i].dest != REG_ZERO))
        pend_mask[mem[i].dest] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - register file write port arbiter for ALU, load and muldiv results
// Optional WB_FWD_EN adds fwd_valid/fwd_addr/fwd_data bypass outputs.
module regfile_writeback
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int NREG  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_dest,
  input  logic [31:0]     alu_data,
  input  logic            ld_valid,
  input  logic [4:0]      ld_dest,
  input  logic [31:0]     ld_word,
  input  logic [2:0]      ld_type,
  input  logic [1:0]      ld_off,
  input  logic            md_valid,
  output logic            md_ready,
  input  logic [4:0]      md_dest,
  input  logic [31:0]     md_data,
  output logic            wb_stall,
  output logic [NREG-1:0] pend_mask,
  output logic            proto_err,
`ifdef WB_FWD_EN
  output logic            fwd_valid,
  output logic [4:0]      fwd_addr,
  output logic [31:0]     fwd_data,
`endif
  output logic [4:0]      writeaddr,
  output logic [31:0]     writedata,
  output logic            regwrite
);

  logic        slot;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  md_entry_t   head;
  md_entry_t   md_in;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_result;

  assign slot     = alu_valid | ld_valid;
  assign pop      = !slot && !fifo_empty;
  assign md_ready = !fifo_full;
  assign wb_stall = fifo_full;
  assign md_in    = '{dest: md_dest, data: md_data};

  assign ld_byte = ld_word[{ld_off, 3'b000} +: 8];
  assign ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    ld_result = ld_word;
    case (ld_type)
      LDT_LB:  ld_result = {{24{ld_byte[7]}}, ld_byte};
      LDT_LBU: ld_result = {24'd0, ld_byte};
      LDT_LH:  ld_result = {{16{ld_half[15]}}, ld_half};
      LDT_LHU: ld_result = {16'd0, ld_half};
      default: ld_result = ld_word;
    endcase
  end

  wb_md_fifo #(.DEPTH(DEPTH), .NREG(NREG)) u_md_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (md_valid && !fifo_full),
    .push_entry (md_in),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .pend_mask  (pend_mask)
  );

  // Load beats ALU on a protocol collision; the FIFO drains only into idle slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite  <= 1'b0;
      writeaddr <= '0;
      writedata <= '0;
      proto_err <= 1'b0;
    end else begin
      if (alu_valid && ld_valid) proto_err <= 1'b1;
      if (ld_valid) begin
        regwrite  <= (ld_dest != REG_ZERO);
        writeaddr <= ld_dest;
        writedata <= ld_result;
      end else if (alu_valid) begin
        regwrite  <= (alu_dest != REG_ZERO);
        writeaddr <= alu_dest;
        writedata <= alu_data;
      end else if (pop) begin
        regwrite  <= (head.dest != REG_ZERO);
        writeaddr <= head.dest;
        writedata <= head.data;
      end else begin
        regwrite  <= 1'b0;
      end
    end
  end

`ifdef WB_FWD_EN
  assign fwd_valid = regwrite;
  assign fwd_addr  = writeaddr;
  assign fwd_data  = writedata;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - directed and random checks of regfile_writeback against a queue model
module tb_regfile_writeback;
  import wb_pkg::*;

  localparam int DEPTH = 2;
  localparam int NREG  = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            alu_valid = 1'b0;
  logic [4:0]      alu_dest = '0;
  logic [31:0]     alu_data = '0;
  logic            ld_valid = 1'b0;
  logic [4:0]      ld_dest = '0;
  logic [31:0]     ld_word = '0;
  logic [2:0]      ld_type = '0;
  logic [1:0]      ld_off = '0;
  logic            md_valid = 1'b0;
  logic            md_ready;
  logic [4:0]      md_dest = '0;
  logic [31:0]     md_data = '0;
  logic            wb_stall;
  logic [NREG-1:0] pend_mask;
  logic            proto_err;
  logic [4:0]      writeaddr;
  logic [31:0]     writedata;
  logic            regwrite;
`ifdef WB_FWD_EN
  logic            fwd_valid;
  logic [4:0]      fwd_addr;
  logic [31:0]     fwd_data;
`endif

  regfile_writeback #(.DEPTH(DEPTH), .NREG(NREG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_dest  (alu_dest),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_dest   (ld_dest),
    .ld_word   (ld_word),
    .ld_type   (ld_type),
    .ld_off    (ld_off),
    .md_valid  (md_valid),
    .md_ready  (md_ready),
    .md_dest   (md_dest),
    .md_data   (md_data),
    .wb_stall  (wb_stall),
    .pend_mask (pend_mask),
    .proto_err (proto_err),
`ifdef WB_FWD_EN
    .fwd_valid (fwd_valid),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data),
`endif
    .writeaddr (writeaddr),
    .writedata (writedata),
    .regwrite  (regwrite)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_ent;
  logic        m_rdy;
  logic        exp_rw = 1'b0;
  logic [4:0]  exp_addr = '0;
  logic [31:0] exp_data = '0;
  logic        exp_err = 1'b0;
  logic        md_acc = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] t, input logic [1:0] off);
    int unsigned sh_b;
    int unsigned sh_h;
    logic [31:0] b;
    logic [31:0] h;
    sh_b = 8 * int'(off);
    sh_h = 16 * (int'(off) / 2);
    b = (w >> sh_b) & 32'hFF;
    h = (w >> sh_h) & 32'hFFFF;
    case (t)
      LDT_LB:  return (b >= 32'h80)   ? (b | 32'hFFFF_FF00) : b;
      LDT_LBU: return b;
      LDT_LH:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      LDT_LHU: return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [NREG-1:0] model_mask();
    logic [NREG-1:0] m;
    m = '0;
    foreach (mq[i]) if (mq[i].dest != 5'd0) m[mq[i].dest] = 1'b1;
    return m;
  endfunction

  // Reference model: a plain queue of outstanding muldiv results and the expected write.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      exp_rw   = 1'b0;
      exp_addr = '0;
      exp_data = '0;
      exp_err  = 1'b0;
    end else begin
      m_rdy = (mq.size() < DEPTH);
      if (alu_valid && ld_valid) exp_err = 1'b1;
      if (ld_valid) begin
        exp_rw = (ld_dest != 5'd0); exp_addr = ld_dest; exp_data = ref_load(ld_word, ld_type, ld_off);
      end else if (alu_valid) begin
        exp_rw = (alu_dest != 5'd0); exp_addr = alu_dest; exp_data = alu_data;
      end else if (mq.size() > 0) begin
        m_ent = mq.pop_front();
        exp_rw = (m_ent.dest != 5'd0); exp_addr = m_ent.dest; exp_data = m_ent.data;
      end else begin
        exp_rw = 1'b0;
      end
      if (md_valid && m_rdy) mq.push_back('{dest: md_dest, data: md_data});
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("regwrite", 64'(regwrite), 64'(exp_rw));
      if (exp_rw) begin
        chk("writeaddr", 64'(writeaddr), 64'(exp_addr));
        chk("writedata", 64'(writedata), 64'(exp_data));
      end
      chk("md_ready", 64'(md_ready), 64'(mq.size() < DEPTH));
      chk("wb_stall", 64'(wb_stall), 64'(mq.size() == DEPTH));
      chk("pend_mask", 64'(pend_mask), 64'(model_mask()));
      chk("proto_err", 64'(proto_err), 64'(exp_err));
`ifdef WB_FWD_EN
      chk("fwd_valid", 64'(fwd_valid), 64'(exp_rw));
      if (exp_rw) begin
        chk("fwd_addr", 64'(fwd_addr), 64'(exp_addr));
        chk("fwd_data", 64'(fwd_data), 64'(exp_data));
      end
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    md_valid  = 1'b0;
  endtask

  logic [2:0]  lt [4];
  logic [1:0]  lo [4];
  logic [31:0] le [4];
  int          r;

  initial begin
    lt[0] = LDT_LB;  lo[0] = 2'd2; le[0] = 32'hFFFF_FFFF;
    lt[1] = LDT_LBU; lo[1] = 2'd3; le[1] = 32'h0000_0080;
    lt[2] = LDT_LH;  lo[2] = 2'd0; le[2] = 32'h0000_7F01;
    lt[3] = LDT_LH;  lo[3] = 2'd2; le[3] = 32'hFFFF_80FF;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_regwrite", 64'(regwrite), 64'd0);
    chk("rst_writeaddr", 64'(writeaddr), 64'd0);
    chk("rst_writedata", 64'(writedata), 64'd0);
    chk("rst_md_ready", 64'(md_ready), 64'd1);
    chk("rst_wb_stall", 64'(wb_stall), 64'd0);
    chk("rst_pend_mask", 64'(pend_mask), 64'd0);
    chk("rst_proto_err", 64'(proto_err), 64'd0);
    rst_n = 1'b1;
    step();

    alu_valid = 1'b1; alu_dest = 5'd5; alu_data = 32'h1234_5678;
    step();
    alu_valid = 1'b0;
    chk("alu_rw", 64'(regwrite), 64'd1);
    chk("alu_addr", 64'(writeaddr), 64'd5);
    chk("alu_data", 64'(writedata), 64'h1234_5678);
    step();
    chk("alu_rw_drop", 64'(regwrite), 64'd0);

    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_dest = 5'(10 + i); ld_word = 32'h80FF_7F01; ld_type = lt[i]; ld_off = lo[i];
      step();
      ld_valid = 1'b0;
      chk("ld_rw", 64'(regwrite), 64'd1);
      chk("ld_ext", 64'(writedata), 64'(le[i]));
    end
    step();

    alu_valid = 1'b1; alu_dest = 5'd1; alu_data = 32'h1;
    md_valid = 1'b1; md_dest = 5'd7; md_data = 32'hAAAA_0007;
    step();
    md_dest = 5'd9; md_data = 32'hBBBB_0009;
    step();
    idle();
    chk("fill_md_ready", 64'(md_ready), 64'd0);
    chk("fill_wb_stall", 64'(wb_stall), 64'd1);
    chk("fill_pend", 64'(pend_mask), 64'h0000_0280);
    step();
    chk("drain7_addr", 64'(writeaddr), 64'd7);
    chk("drain7_data", 64'(writedata), 64'hAAAA_0007);
    chk("drain7_pend", 64'(pend_mask), 64'h0000_0200);
    step();
    chk("drain9_addr", 64'(writeaddr), 64'd9);
    chk("drain9_data", 64'(writedata), 64'hBBBB_0009);
    chk("drain9_pend", 64'(pend_mask), 64'd0);
    step();
    chk("drain_done_rw", 64'(regwrite), 64'd0);
    chk("drain_done_ready", 64'(md_ready), 64'd1);

    alu_valid = 1'b1; alu_dest = 5'd0; alu_data = 32'hDEAD_BEEF;
    step();
    alu_valid = 1'b0;
    chk("alu_r0_rw", 64'(regwrite), 64'd0);
    md_valid = 1'b1; md_dest = 5'd0; md_data = 32'h0BAD_0000;
    step();
    md_valid = 1'b0;
    chk("md_r0_pend", 64'(pend_mask), 64'd0);
    step();
    chk("md_r0_rw", 64'(regwrite), 64'd0);
    chk("md_r0_pend_after", 64'(pend_mask), 64'd0);

    alu_valid = 1'b1; alu_dest = 5'd3; alu_data = 32'h0000_AAAA;
    ld_valid = 1'b1; ld_dest = 5'd4; ld_word = 32'hCAFE_F00D; ld_type = LDT_LW; ld_off = 2'd1;
    step();
    idle();
    chk("proto_addr", 64'(writeaddr), 64'd4);
    chk("proto_data", 64'(writedata), 64'hCAFE_F00D);
    chk("proto_err_set", 64'(proto_err), 64'd1);
    step();
    chk("proto_err_sticky", 64'(proto_err), 64'd1);

    alu_valid = 1'b1; alu_dest = 5'd2; alu_data = 32'h55;
    md_valid = 1'b1; md_dest = 5'd12; md_data = 32'h12;
    step();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rw", 64'(regwrite), 64'd0);
    chk("async_rst_ready", 64'(md_ready), 64'd1);
    chk("async_rst_pend", 64'(pend_mask), 64'd0);
    chk("async_rst_err", 64'(proto_err), 64'd0);
    step();
    rst_n = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      md_acc = md_valid && md_ready;
      step();
      alu_valid = 1'b0;
      ld_valid  = 1'b0;
      if (!wb_stall) begin
        r = $urandom_range(0, 3);
        alu_valid = (r == 1);
        ld_valid  = (r == 2);
      end
      alu_dest = 5'($urandom); alu_data = $urandom;
      ld_dest = 5'($urandom); ld_word = $urandom; ld_type = 3'($urandom); ld_off = 2'($urandom);
      if (!md_valid || md_acc) begin
        md_valid = ($urandom_range(0, 2) == 0);
        md_dest  = 5'($urandom);
        md_data  = $urandom;
      end
    end
    idle();
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
